layer_mac_engine: RTL
=====================

LAYER_MAC_ENGINE -- requirements
Module: layer_mac_engine

Interface
REQ-001 SHALL have parameter N_IN, default 10: number of input words per neuron.
REQ-002 SHALL have parameter N_OUT, default 5: number of neurons (output words).
REQ-003 SHALL have parameter DATA_W, default 10: unsigned input and output word width.
REQ-004 SHALL have parameter WEIGHT_W, default 10: signed two's-complement weight width.
REQ-005 SHALL have parameter FRAC_BITS, default 4: arithmetic right shift applied to the accumulator before activation.
REQ-006 SHALL have port Clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port Rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have ports in_we (in, 1), in_addr (in, clog2(N_IN)) and in_data (in, DATA_W): input word write port.
REQ-009 SHALL have ports w_we (in, 1), w_addr (in, clog2(N_IN*N_OUT)) and w_data (in, WEIGHT_W): weight write port; weight index = neuron*N_IN + input.
REQ-010 SHALL have ports b_we (in, 1), b_addr (in, clog2(N_OUT)) and b_data (in, WEIGHT_W+DATA_W): per-neuron signed bias write port.
REQ-011 SHALL have port start, input, 1 bit: single-cycle request to evaluate the layer.
REQ-012 SHALL have ports busy (out, 1) and done (out, 1): busy is high while evaluating; done is a one-cycle completion pulse.
REQ-013 SHALL have ports rd_addr (in, clog2(N_OUT)) and rd_data (out, DATA_W): combinational readback of output word rd_addr.
REQ-014 SHALL have port state (out, 3): current FSM state encoding for debug display.

Function
REQ-015 SHALL implement the FSM states IDLE=0, MAC=1, ACT=2, DONE=3.
REQ-016 In IDLE, start SHALL clear the neuron and input counters and the accumulator, and move to MAC on the next edge.
REQ-017 In MAC, each cycle SHALL add in[i]*w[n*N_IN+i] (signed, zero-extended input) to the accumulator.
REQ-018 MAC SHALL last exactly N_IN cycles per neuron and then move to ACT.
REQ-019 In ACT, the FSM SHALL compute y = (acc + bias[n]) >>> FRAC_BITS and clamp it to the range [0, 2^DATA_W-1] (ReLU with saturation).
REQ-020 In ACT, the FSM SHALL write y to out[n], then clear acc and go to MAC for n+1, or to DONE if n = N_OUT-1.
REQ-021 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-022 Latency from the start edge to the done pulse SHALL be N_OUT*(N_IN+1)+1 cycles; busy SHALL be high in MAC and ACT.
REQ-023 The accumulator SHALL be DATA_W+WEIGHT_W+clog2(N_IN)+1 bits wide so that it cannot overflow.
REQ-024 start while busy SHALL be ignored.
REQ-025 in_we, w_we and b_we while busy SHALL be ignored, so operands are frozen during evaluation.
REQ-026 If in_we and start are both asserted in the same IDLE cycle, the write SHALL commit and the evaluation SHALL use the new value.
REQ-027 Out-of-range write addresses SHALL be ignored; an out-of-range rd_addr SHALL return 0.
REQ-028 During busy, rd_data SHALL return the old out[n] until neuron n is written in ACT.

Reset
REQ-029 Rst high SHALL asynchronously force IDLE, busy=0, done=0, acc=0, counters=0, and all out[], in[], weights and biases to 0.
REQ-030 Rst asserted mid-evaluation SHALL abort it with no done pulse; the first start after Rst deasserts SHALL run a full evaluation.

Configuration
REQ-031 With macro LAYER_BIAS_EN defined, the bias storage and the bias add in ACT SHALL be present.
REQ-032 Without LAYER_BIAS_EN, the bias term SHALL be 0, b_we SHALL be ignored, and the bias storage SHALL not be synthesised.

Verification
REQ-033 Defaults; all inputs 1, all weights 16, bias 0, start -> done at cycle 56; every out = 10.
REQ-034 Input 1023 on all inputs, weights 511, bias 0 -> every out saturates to 1023.
REQ-035 Weights -5, inputs 100 -> every out = 0 (ReLU clamp); with LAYER_BIAS_EN and bias[2]=20000 -> out[2] = (20000-5000)>>>4 = 937.
REQ-036 start pulsed again at cycle 10 of a run -> ignored, single done at cycle 56; in_we at cycle 10 -> in[] unchanged.
REQ-037 Rst at cycle 30 of a run -> state=0, busy=0, out[] = 0, no done; rerun -> done 56 cycles after start.
REQ-038 Without LAYER_BIAS_EN, b_we with 20000 then the REQ-035 run -> out[2] = 0.

Source files
------------

// File: rtl/layer_mac_engine.sv
// Fully-connected layer evaluator: one multiply-accumulate per cycle, then a ReLU with saturation per neuron.
// Define LAYER_BIAS_EN to build the per-neuron bias storage and the bias add; without it the bias term is 0.
module layer_mac_engine #(
  parameter int N_IN      = 10,
  parameter int N_OUT     = 5,
  parameter int DATA_W    = 10,
  parameter int WEIGHT_W  = 10,
  parameter int FRAC_BITS = 4
) (
  input  logic                          Clock,
  input  logic                          Rst,
  input  logic                          in_we,
  input  logic [$clog2(N_IN)-1:0]       in_addr,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          w_we,
  input  logic [$clog2(N_IN*N_OUT)-1:0] w_addr,
  input  logic [WEIGHT_W-1:0]           w_data,
  input  logic                          b_we,
  input  logic [$clog2(N_OUT)-1:0]      b_addr,
  input  logic [WEIGHT_W+DATA_W-1:0]    b_data,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  input  logic [$clog2(N_OUT)-1:0]      rd_addr,
  output logic [DATA_W-1:0]             rd_data,
  output logic [2:0]                    state
);
  localparam int IN_AW  = $clog2(N_IN);
  localparam int W_AW   = $clog2(N_IN*N_OUT);
  localparam int OUT_AW = $clog2(N_OUT);
  localparam int BIAS_W = WEIGHT_W + DATA_W;
  localparam int PROD_W = DATA_W + 1 + WEIGHT_W;
  localparam int ACC_W  = DATA_W + WEIGHT_W + $clog2(N_IN) + 1;
  localparam int SUM_W  = ACC_W + 1;
  localparam logic signed [SUM_W-1:0] Y_MAX = SUM_W'((64'd1 << DATA_W) - 64'd1);

  typedef enum logic [2:0] {IDLE = 3'd0, MAC = 3'd1, ACT = 3'd2, DONE = 3'd3} state_t;

  state_t                    state_q, state_d;
  logic [OUT_AW-1:0]         n_q, n_d;
  logic [IN_AW-1:0]          i_q, i_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]         in_mem_q  [N_IN];
  logic [DATA_W-1:0]         in_mem_d  [N_IN];
  logic [WEIGHT_W-1:0]       w_mem_q   [N_IN*N_OUT];
  logic [WEIGHT_W-1:0]       w_mem_d   [N_IN*N_OUT];
  logic [DATA_W-1:0]         out_mem_q [N_OUT];
  logic [DATA_W-1:0]         out_mem_d [N_OUT];
  logic signed [BIAS_W-1:0]  bias_sel;
  logic                      wr_open;
  logic [W_AW-1:0]           w_idx;
  logic signed [PROD_W-1:0]  prod;
  logic signed [SUM_W-1:0]   sum;
  logic signed [SUM_W-1:0]   shifted;
  logic [DATA_W-1:0]         y;

  assign busy    = (state_q == MAC) || (state_q == ACT);
  assign done    = (state_q == DONE);
  assign state   = state_q;
  assign wr_open = !busy;

  // Operands are zero-extended inputs times signed weights; the accumulator is sized to never wrap.
  assign w_idx   = W_AW'(32'(n_q) * N_IN + 32'(i_q));
  assign prod    = PROD_W'($signed({1'b0, in_mem_q[i_q]})) * PROD_W'($signed(w_mem_q[w_idx]));
  assign sum     = SUM_W'(acc_q) + SUM_W'(bias_sel);
  assign shifted = sum >>> FRAC_BITS;
  assign rd_data = (32'(rd_addr) < N_OUT) ? out_mem_q[rd_addr] : '0;

  always_comb begin
    if (shifted[SUM_W-1])    y = '0;
    else if (shifted > Y_MAX) y = '1;
    else                      y = shifted[DATA_W-1:0];
  end

`ifdef LAYER_BIAS_EN
  logic signed [BIAS_W-1:0] b_mem_q [N_OUT];
  logic signed [BIAS_W-1:0] b_mem_d [N_OUT];

  always_comb begin
    b_mem_d = b_mem_q;
    if (b_we && wr_open && (32'(b_addr) < N_OUT)) b_mem_d[b_addr] = b_data;
  end

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) for (int k = 0; k < N_OUT; k++) b_mem_q[k] <= '0;
    else     b_mem_q <= b_mem_d;
  end

  assign bias_sel = b_mem_q[n_q];
`else
  logic unused_bias;
  assign unused_bias = ^{b_we, b_addr, b_data};
  assign bias_sel    = '0;
`endif

  // Operand writes are only accepted outside MAC/ACT, so an evaluation sees frozen operands.
  always_comb begin
    in_mem_d = in_mem_q;
    w_mem_d  = w_mem_q;
    if (in_we && wr_open && (32'(in_addr) < N_IN))       in_mem_d[in_addr] = in_data;
    if (w_we && wr_open && (32'(w_addr) < N_IN * N_OUT)) w_mem_d[w_addr]   = w_data;
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    i_d       = i_q;
    acc_d     = acc_q;
    out_mem_d = out_mem_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          n_d     = '0;
          i_d     = '0;
          acc_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + ACC_W'(prod);
        if (32'(i_q) == N_IN - 1) begin
          i_d     = '0;
          state_d = ACT;
        end else begin
          i_d = i_q + IN_AW'(1);
        end
      end
      ACT: begin
        out_mem_d[n_q] = y;
        acc_d          = '0;
        if (32'(n_q) == N_OUT - 1) begin
          state_d = DONE;
        end else begin
          n_d     = n_q + OUT_AW'(1);
          state_d = MAC;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      i_q     <= '0;
      acc_q   <= '0;
      for (int k = 0; k < N_IN; k++)         in_mem_q[k]  <= '0;
      for (int k = 0; k < N_IN * N_OUT; k++) w_mem_q[k]   <= '0;
      for (int k = 0; k < N_OUT; k++)        out_mem_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      i_q       <= i_d;
      acc_q     <= acc_d;
      in_mem_q  <= in_mem_d;
      w_mem_q   <= w_mem_d;
      out_mem_q <= out_mem_d;
    end
  end
endmodule
